// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion block.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BCD_DIGITS = 3;
  localparam int DEC_MAX    = 999;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/bcd3_convert_if.sv
// Request/result bundle between the subtract stage, the converter and the digit renderer.
interface bcd3_convert_if #(
  parameter int N      = 10,
  parameter int DIGITS = 3
);
  // Handshake: a request is start=1 while the converter is idle (busy=0, or the
  // done cycle itself); start while converting is dropped, never queued.
  // done pulses for one cycle when bcd/neg/err carry the new result.
  logic                  start;
  logic [N-1:0]          bin;
  logic                  borrow_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  err;

  modport master (
    output start, bin, borrow_in,
    input  busy, done, bcd, neg, err
  );

  modport slave (
    input  start, bin, borrow_in,
    output busy, done, bcd, neg, err
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd3_convert.sv
// Sequential shift-and-add-3 converter: one input bit per clock, results held
// until the next conversion completes.
module bcd3_convert
  import bcd_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd3_convert_if.slave io,
  output state_t       dbg_state
);

  localparam int             BW      = 4 * DIGITS;
  localparam logic [N-1:0]   MAX_BIN = N'(DEC_MAX);
  localparam logic [BW-1:0]  SAT_BCD = {DIGITS{4'd9}};

  state_t            state_q, state_d;
  logic [N-1:0]      sr_q, sr_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;
  logic [BW-1:0]     bcd_out_q, bcd_out_d;
  logic              neg_out_q, neg_out_d;
  logic              err_out_q, err_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BW-1:0]     acc_corr;
  logic [BW-1:0]     acc_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc_q[4*g +: 4]),
      .dout (acc_corr[4*g +: 4])
    );
  end

  // The carry out of the top digit only exists for out-of-range inputs,
  // whose result is replaced by the saturated value anyway.
  assign acc_shift = BW'({acc_corr, sr_q[N-1]});

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    err_d     = err_q;
    bcd_out_d = bcd_out_q;
    neg_out_d = neg_out_q;
    err_out_d = err_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (io.start) begin
          sr_d    = io.bin;
          neg_d   = io.borrow_in;
          err_d   = (io.bin > MAX_BIN);
          acc_d   = '0;
          cnt_d   = CNT_W'(N);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        acc_d  = acc_shift;
        sr_d   = {sr_q[N-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_out_d = err_q ? SAT_BCD : acc_shift;
          neg_out_d = neg_q;
          err_out_d = err_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      bcd_out_q <= '0;
      neg_out_q <= 1'b0;
      err_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      bcd_out_q <= bcd_out_d;
      neg_out_q <= neg_out_d;
      err_out_q <= err_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.bcd    = bcd_out_q;
  assign io.neg    = neg_out_q;
  assign io.err    = err_out_q;
  assign dbg_state = state_q;

endmodule
